// File: rtl/vga_pixel_sink.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_sink
//  Description : Pixel-plot receiver with a 160x120x3 framebuffer, scanned
//                out as 640x480@60 Hz VGA with 4x4 pixel replication.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_sink #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_W      = 160,
    parameter int FB_H      = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] color,
    input  logic       plot,
    output logic       plot_dropped,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    // ------------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------------
    localparam int CNT_W    = 10;
    localparam int ADDR_W   = 15;
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int FB_DEPTH = FB_W * FB_H;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [7:0]       FB_W_C     = 8'(FB_W);
    localparam logic [6:0]       FB_H_C     = 7'(FB_H);
    localparam logic [ADDR_W-1:0] FB_DEPTH_C = ADDR_W'(FB_DEPTH);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic              pix_en_q;
    logic [CNT_W-1:0]  hcount_q, hcount_d;
    logic [CNT_W-1:0]  vcount_q, vcount_d;

    logic              visible;
    logic              hsync_raw;
    logic              vsync_raw;

    logic              wr_in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    logic [7:0]        rd_row;
    logic [7:0]        rd_col;
    logic [ADDR_W-1:0] rd_addr_full;
    logic [ADDR_W-1:0] rd_addr;

    logic [2:0]        fb_mem [FB_DEPTH];

    // Stage 1: timing delayed one pixel step alongside the memory read
    logic              vis_s1_q;
    logic              hs_s1_q;
    logic              vs_s1_q;
    logic [2:0]        rd_data_q;

    // Stage 2: output registers
    logic              hs_q;
    logic              vs_q;
    logic              blank_n_q;
    logic [2:0]        rgb_q;

    logic              plot_dropped_q;

    // ------------------------------------------------------------------------
    // Pixel-enable divider: one 25 MHz pixel step every other 50 MHz clock
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
        end
    end

    // ------------------------------------------------------------------------
    // Scan counters: next-state, advancing only on pixel steps
    // ------------------------------------------------------------------------
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    // Scan counters: state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // ------------------------------------------------------------------------
    // Raw timing decode from the registered counters (syncs active low)
    // ------------------------------------------------------------------------
    assign visible   = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
    assign hsync_raw = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    assign vsync_raw = !((vcount_q >= VS_START) && (vcount_q < VS_END));

    // One cycle wide because pix_en is high for only one clk per step
    assign frame_start = pix_en_q && (hcount_q == '0) && (vcount_q == '0);

    // ------------------------------------------------------------------------
    // Write port: runs every clk, independent of the pixel step.
    // Row offset y*160 is built as (y<<7)+(y<<5) to avoid a multiplier.
    // ------------------------------------------------------------------------
    assign wr_in_range = (x < FB_W_C) && (y < FB_H_C);
    assign wr_en       = plot && wr_in_range;
    assign wr_addr     = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};

    // Framebuffer array; deliberately not reset so the image survives a reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= color;
        end
    end

    // Reports a rejected out-of-range plot one cycle after it was presented
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot_dropped_q <= 1'b0;
        end else begin
            plot_dropped_q <= plot && !wr_in_range;
        end
    end

    // ------------------------------------------------------------------------
    // Read address: each framebuffer pixel covers a 4x4 screen block.
    // Outside the visible area the computed address can exceed the array;
    // it is clamped to 0 there since that data is blanked anyway.
    // ------------------------------------------------------------------------
    assign rd_row       = vcount_q[CNT_W-1:2];
    assign rd_col       = hcount_q[CNT_W-1:2];
    assign rd_addr_full = {rd_row, 7'b0} + {2'b0, rd_row, 5'b0} + {7'b0, rd_col};
    assign rd_addr      = (rd_addr_full < FB_DEPTH_C) ? rd_addr_full : '0;

    // ------------------------------------------------------------------------
    // Stage 1: registered memory read plus matching delay of the timing
    // signals. A same-cycle write to this address leaves the old data here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vis_s1_q  <= 1'b0;
            hs_s1_q   <= 1'b1;
            vs_s1_q   <= 1'b1;
            rd_data_q <= '0;
        end else if (pix_en_q) begin
            vis_s1_q  <= visible;
            hs_s1_q   <= hsync_raw;
            vs_s1_q   <= vsync_raw;
            rd_data_q <= fb_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: output registers; colour forced to black outside visible area
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else if (pix_en_q) begin
            hs_q      <= hs_s1_q;
            vs_q      <= vs_s1_q;
            blank_n_q <= vis_s1_q;
            rgb_q     <= vis_s1_q ? rd_data_q : 3'b000;
        end
    end

    // ------------------------------------------------------------------------
    // Output drive: each colour bit fans out to a full-scale 8-bit channel
    // ------------------------------------------------------------------------
    assign VGA_R        = {8{rgb_q[2]}};
    assign VGA_G        = {8{rgb_q[1]}};
    assign VGA_B        = {8{rgb_q[0]}};
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign VGA_SYNC_N   = 1'b0;
    assign VGA_CLK      = pix_en_q;
    assign plot_dropped = plot_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_sink
//  Description : Self-checking scoreboard bench for vga_pixel_sink.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_sink;

    localparam int FBW = 160;
    localparam int FBH = 120;
    localparam int FBD = FBW * FBH;
    localparam logic [26:0] RST_PAT = {1'b1, 1'b1, 1'b0, 24'h000000};

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       plot_dropped, frame_start;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    always #10 clk = ~clk;

    vga_pixel_sink dut (
        .clk          (clk),
        .resetn       (resetn),
        .x            (x),
        .y            (y),
        .color        (color),
        .plot         (plot),
        .plot_dropped (plot_dropped),
        .frame_start  (frame_start),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .VGA_BLANK_N  (VGA_BLANK_N),
        .VGA_SYNC_N   (VGA_SYNC_N),
        .VGA_CLK      (VGA_CLK)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    bit          run_first;
    logic [2:0]  fb_m [FBD];
    logic [26:0] sb_q [$];
    logic [26:0] cur_exp;
    logic        drop_exp;
    logic        prev_hs;
    int          hs_falls [$];
    int          hs_rises [$];

    // Single comparison point: counts and reports any mismatch
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [26:0] exp_pack(input logic hs, input logic vs,
                                             input logic vis, input logic [2:0] c);
        logic [2:0] cc;
        cc = vis ? c : 3'b000;
        return {hs, vs, vis, {8{cc[2]}}, {8{cc[1]}}, {8{cc[0]}}};
    endfunction

    task automatic set_plot(input int px, input int py, input int pc);
        plot  = 1'b1;
        x     = 8'(px);
        y     = 7'(py);
        color = 3'(pc);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_hs"},    VGA_HS, 1);
        check_val({pfx, "_vs"},    VGA_VS, 1);
        check_val({pfx, "_blank"}, VGA_BLANK_N, 0);
        check_val({pfx, "_rgb"},   {VGA_R, VGA_G, VGA_B}, 0);
        check_val({pfx, "_drop"},  plot_dropped, 0);
        check_val({pfx, "_fs"},    frame_start, 0);
        check_val({pfx, "_pclk"},  VGA_CLK, 0);
    endtask

    task automatic restart_tracking();
        cyc      = 0;
        sb_q.delete();
        cur_exp  = RST_PAT;
        drop_exp = 1'b0;
        prev_hs  = 1'b1;
        hs_falls.delete();
        hs_rises.delete();
    endtask

    // Stimulus for the current cycle: background random plots plus fixed events
    task automatic drive(input int c);
        plot = 1'b0; x = '0; y = '0; color = '0;
        if ($urandom_range(7) == 0)
            set_plot(int'($urandom_range(170)), int'($urandom_range(127)), int'($urandom_range(7)));
        if (run_first) begin
            case (c)
                100:   set_plot(5, 3, 4);
                102:   set_plot(160, 0, 7);
                104:   set_plot(0, 120, 7);
                106:   set_plot(255, 127, 1);
                110:   set_plot(159, 119, 7);
                111:   set_plot(0, 0, 2);
                12881: set_plot(10, 2, int'(~fb_m[330]));  // same edge as read of (40,8)
                14601: set_plot(25, 2, int'(~fb_m[345]));  // same edge as read of (100,9)
                16120: set_plot(15, 2, int'(~fb_m[335]));  // one clk before read of (60,10)
                default: ;
            endcase
        end
    endtask

    // Check the current cycle, push the expectation for this pixel step,
    // apply this cycle's plot to the model, then advance one clk
    task automatic tick();
        logic [26:0] exp_o;
        int s, h, v;
        logic vis, hs, vs;
        logic [2:0] pix;

        check_val("frame_start", frame_start, (cyc == 1) ? 1 : 0);
        check_val("vga_clk", VGA_CLK, cyc % 2);
        check_val("plot_dropped", plot_dropped, drop_exp);

        if (cyc < 4) begin
            exp_o = RST_PAT;
        end else begin
            if (cyc % 2 == 0) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 0, 1);
                    cur_exp = RST_PAT;
                end else begin
                    cur_exp = sb_q.pop_front();
                end
            end
            exp_o = cur_exp;
        end
        check_val("vga_out", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, exp_o);

        if (prev_hs && !VGA_HS) hs_falls.push_back(cyc);
        if (!prev_hs && VGA_HS) hs_rises.push_back(cyc);
        prev_hs = VGA_HS;

        if (cyc % 2 == 1) begin
            s   = (cyc - 1) / 2;
            h   = s % 800;
            v   = (s / 800) % 525;
            vis = (h < 640) && (v < 480);
            hs  = !(h >= 656 && h <= 751);
            vs  = !(v >= 490 && v <= 491);
            pix = vis ? fb_m[(v / 4) * FBW + (h / 4)] : 3'b000;
            sb_q.push_back(exp_pack(hs, vs, vis, pix));
        end

        drop_exp = plot && !((int'(x) < FBW) && (int'(y) < FBH));
        if (plot && (int'(x) < FBW) && (int'(y) < FBH))
            fb_m[int'(y) * FBW + int'(x)] = color;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_hs_timing(input string pfx);
        if (hs_falls.size() > 0) check_val({pfx, "_hs_fall1"}, hs_falls[0], 1316);
        else                     check_val({pfx, "_hs_fall1_missing"}, 0, 1);
        if (hs_rises.size() > 0) check_val({pfx, "_hs_rise1"}, hs_rises[0], 1508);
        else                     check_val({pfx, "_hs_rise1_missing"}, 0, 1);
        if (hs_falls.size() > 1) check_val({pfx, "_hs_fall2"}, hs_falls[1], 2916);
        else                     check_val({pfx, "_hs_fall2_missing"}, 0, 1);
    endtask

    initial begin
        resetn = 1'b0;
        plot = 1'b0; x = '0; y = '0; color = '0;
        run_first = 1'b1;
        restart_tracking();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("cold_rst");
        check_val("sync_n", VGA_SYNC_N, 0);

        // Preload the whole framebuffer with a known pattern while held in reset
        for (int a = 0; a < FBD; a++) begin
            set_plot(a % FBW, a / FBW, ((a % FBW) + 2 * (a / FBW)) % 8);
            fb_m[a] = 3'(((a % FBW) + 2 * (a / FBW)) % 8);
            @(posedge clk);
            #1;
        end
        plot = 1'b0;
        @(posedge clk);
        #1;
        check_val("drop_in_reset", plot_dropped, 0);

        // Cold start: scan ~17 lines, then reset mid-line at hcount 300
        resetn = 1'b1;
        restart_tracking();
        while (cyc < 27800) begin
            drive(cyc);
            tick();
        end
        check_hs_timing("run1");

        plot   = 1'b0;
        resetn = 1'b0;
        #2;
        check_reset_outputs("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("mid_rst_hold");

        // Restart after reset: timing must match the cold start
        run_first = 1'b0;
        resetn    = 1'b1;
        restart_tracking();
        while (cyc < 3400) begin
            drive(cyc);
            tick();
        end
        check_hs_timing("run2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
